// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, FSM states,
// PC queue depth and the sequential-PC helper.
package if_stage_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    // Must match the number of responses ID can buffer while stalled.
    localparam int PCQ_DEPTH = 2;

    typedef enum logic [1:0] {
        IF_BOOT,
        IF_WAIT,
        IF_DROP,
        IF_HOLD
    } if_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch request/response bus between the IF stage (master) and the Icache (slave).
interface if_stage_if;

    logic        if_Icache_req;
    logic [31:0] if_Icache_addr;
    logic        Icache_ready;

    modport master (output if_Icache_req, output if_Icache_addr, input Icache_ready);
    modport slave  (input if_Icache_req, input if_Icache_addr, output Icache_ready);

endinterface

// File: rtl/if_stage_pc_queue.sv
// Two-entry FIFO holding the PCs of fetched instructions not yet consumed by ID.
module pc_queue
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] data_i,
    output logic [31:0] head_o,
    output logic        empty_o,
    output logic        full_o
);

    logic [31:0] mem_q [PCQ_DEPTH];
    logic        rd_q;
    logic        wr_q;
    logic [1:0]  cnt_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'(PCQ_DEPTH));
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: RESET_PC};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (clear_i) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one Icache request in flight,
// applies redirects and drops responses that belong to the old path.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_jump_flag_i,
    input  logic [31:0] fc_jump_pc_i,
    input  logic        fc_stall_if_i,
    if_stage_if.master  icache,
    output logic        if_inst_valid_o,
    output logic [31:0] if_pc_o
);

    if_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  stall_cnt_q, stall_cnt_d;
    logic        live;
    logic        bypass;
    logic        q_push;
    logic        q_pop;
    logic        q_empty;
    logic        q_full;
    logic [31:0] q_head;

    pc_queue #(.RESET_PC(RESET_PC)) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (fc_jump_flag_i),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  (addr_q),
        .head_o  (q_head),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= RESET_PC;
            stall_cnt_q <= 2'd0;
        end else begin
            addr_q      <= addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // stall_cnt tracks how many responses ID is holding; at the buffer depth we park in HOLD.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stall_cnt_d = stall_cnt_q;
        if (q_push && !q_pop) begin
            stall_cnt_d = stall_cnt_q + 2'd1;
        end else if (q_pop && !q_push) begin
            stall_cnt_d = stall_cnt_q - 2'd1;
        end
        if (fc_jump_flag_i) begin
            addr_d      = fc_jump_pc_i;
            stall_cnt_d = 2'd0;
            // A DROP whose stale response lands this cycle has nothing left to discard.
            if ((state_q == IF_WAIT || state_q == IF_DROP) && !icache.Icache_ready) begin
                state_d = IF_DROP;
            end else begin
                state_d = IF_WAIT;
            end
        end else begin
            case (state_q)
                IF_BOOT: state_d = IF_WAIT;
                IF_WAIT: begin
                    if (live) begin
                        addr_d = pc_plus4(addr_q);
                        if (fc_stall_if_i && stall_cnt_q == 2'(PCQ_DEPTH - 1)) begin
                            state_d = IF_HOLD;
                        end
                    end
                end
                IF_DROP: begin
                    if (icache.Icache_ready) begin
                        state_d = IF_WAIT;
                    end
                end
                IF_HOLD: begin
                    if (!fc_stall_if_i) begin
                        state_d = IF_WAIT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        icache.if_Icache_req  = (state_q == IF_WAIT);
        icache.if_Icache_addr = addr_q;
        live                  = (state_q == IF_WAIT) && icache.Icache_ready;
        bypass                = live && !fc_stall_if_i && q_empty;
        q_push                = live && !bypass;
        q_pop                 = !fc_stall_if_i && !q_empty;
        if_inst_valid_o       = live;
        if_pc_o               = bypass ? addr_q : q_head;
    end

    // ID never holds more than the queue depth, so an overflowing push is a design bug.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(q_push && q_full && !q_pop && !fc_jump_flag_i));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random stall/redirect
// traffic, checked against a queue-based fetch model and a latency-driven Icache model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump;
    logic [31:0] jumpPc;
    logic        stall;
    logic        valid;
    logic [31:0] pc;

    if_stage_if icacheBus ();

    if_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fc_jump_flag_i  (jump),
        .fc_jump_pc_i    (jumpPc),
        .fc_stall_if_i   (stall),
        .icache          (icacheBus),
        .if_inst_valid_o (valid),
        .if_pc_o         (pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of the fetch stream.
    logic [31:0] mFetch;
    bit          mStarted;
    bit          mDiscard;
    bit          mParked;
    logic [31:0] mQ[$];

    // Icache responder: one response per request after a chosen latency.
    bit icPending;
    int icCount;
    int icLat;
    bit icRandom;

    logic        obsReq;
    logic [31:0] obsAddr;
    logic        obsValid;
    logic [31:0] obsPc;
    logic        obsReady;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mFetch   = IF_RESET_PC;
        mStarted = 1'b0;
        mDiscard = 1'b0;
        mParked  = 1'b0;
        mQ.delete();
    endtask

    task automatic checkOutput();
        logic        expReq;
        logic        expValid;
        logic        consume;
        logic [31:0] expPc;
        expReq   = mStarted && !mDiscard && !mParked;
        expValid = expReq && icacheBus.Icache_ready;
        consume  = !stall && (mQ.size() > 0 || expValid);
        expPc    = (mQ.size() > 0) ? mQ[0] : mFetch;
        obsReq   = icacheBus.if_Icache_req;
        obsAddr  = icacheBus.if_Icache_addr;
        obsValid = valid;
        obsPc    = pc;
        obsReady = icacheBus.Icache_ready;
        total++;
        assert (obsReq === expReq) else begin
            bad++;
            $error("[TB] FAIL req: observed=%0b expected=%0b", obsReq, expReq);
        end
        if (expReq) begin
            total++;
            assert (obsAddr === mFetch) else begin
                bad++;
                $error("[TB] FAIL addr: observed=%h expected=%h", obsAddr, mFetch);
            end
        end
        total++;
        assert (obsValid === expValid) else begin
            bad++;
            $error("[TB] FAIL valid: observed=%0b expected=%0b", obsValid, expValid);
        end
        if (consume) begin
            total++;
            assert (obsPc === expPc) else begin
                bad++;
                $error("[TB] FAIL pc: observed=%h expected=%h", obsPc, expPc);
            end
        end
    endtask

    task automatic modelUpdate();
        bit expReq;
        bit rdy;
        bit popNow;
        expReq = mStarted && !mDiscard && !mParked;
        rdy    = icacheBus.Icache_ready;
        popNow = !stall && mQ.size() > 0;
        if (jump) begin
            mDiscard = (expReq && !rdy) || (mDiscard && !rdy);
            mFetch   = jumpPc;
            mParked  = 1'b0;
            mStarted = 1'b1;
            mQ.delete();
        end else if (!mStarted) begin
            mStarted = 1'b1;
        end else begin
            if (popNow) void'(mQ.pop_front());
            if (mDiscard) begin
                if (rdy) mDiscard = 1'b0;
            end else if (mParked) begin
                if (!stall) mParked = 1'b0;
            end else if (rdy) begin
                if (stall || popNow) mQ.push_back(mFetch);
                mFetch = mFetch + 32'd4;
                if (stall && mQ.size() == PCQ_DEPTH) mParked = 1'b1;
            end
        end
    endtask

    // Called at posedge+1; drives one cycle, checks mid-cycle, advances to the next posedge+1.
    task automatic applyStimulus(input bit s, input bit j, input logic [31:0] t);
        stall  = s;
        jump   = j;
        jumpPc = t;
        if (!icPending && icacheBus.if_Icache_req) begin
            icPending = 1'b1;
            icCount   = icRandom ? int'($urandom_range(0, 3)) : icLat;
        end
        if (icPending && icCount == 0) begin
            icacheBus.Icache_ready = 1'b1;
            icPending              = 1'b0;
        end else begin
            icacheBus.Icache_ready = 1'b0;
            if (icPending) icCount--;
        end
        #4;
        checkOutput();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n                  = 1'b0;
        stall                  = 1'b0;
        jump                   = 1'b0;
        icacheBus.Icache_ready = 1'b0;
        icPending              = 1'b0;
        modelReset();
        #4;
        checkValue("rst_req", {31'd0, icacheBus.if_Icache_req}, 32'd0);
        checkValue("rst_addr", icacheBus.if_Icache_addr, IF_RESET_PC);
        checkValue("rst_valid", {31'd0, valid}, 32'd0);
        checkValue("rst_pc", pc, IF_RESET_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n                  = 1'b0;
        stall                  = 1'b0;
        jump                   = 1'b0;
        jumpPc                 = 32'd0;
        icacheBus.Icache_ready = 1'b0;
        icPending              = 1'b0;
        icCount                = 0;
        icLat                  = 0;
        icRandom               = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        doReset();

        // BOOT cycle, then straight-line fetch with ready every cycle.
        applyStimulus(0, 0, 32'd0);
        checkValue("boot_req", {31'd0, obsReq}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 32'd0);
            checkValue("seq_addr", obsAddr, 32'(4 * i));
            checkValue("seq_pc", obsPc, 32'(4 * i));
        end

        // Stall for four cycles: two responses buffered, then parked.
        applyStimulus(1, 0, 32'd0);
        checkValue("stall_addr0", obsAddr, 32'h10);
        applyStimulus(1, 0, 32'd0);
        checkValue("stall_addr1", obsAddr, 32'h14);
        applyStimulus(1, 0, 32'd0);
        checkValue("hold_req", {31'd0, obsReq}, 32'd0);
        applyStimulus(1, 0, 32'd0);
        applyStimulus(0, 0, 32'd0);
        checkValue("release_pc0", obsPc, 32'h10);
        applyStimulus(0, 0, 32'd0);
        checkValue("release_pc1", obsPc, 32'h14);
        checkValue("reissue_addr", obsAddr, 32'h18);
        applyStimulus(0, 0, 32'd0);

        // Redirect while 0x20 is outstanding; its response arrives three cycles later.
        icLat = 3;
        applyStimulus(0, 1, 32'h200);
        checkValue("redir_addr", obsAddr, 32'h20);
        icLat = 0;
        applyStimulus(0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0);
        checkValue("drop_ready", {31'd0, obsReady}, 32'd1);
        checkValue("drop_valid", {31'd0, obsValid}, 32'd0);
        applyStimulus(0, 0, 32'd0);
        checkValue("target_pc", obsPc, 32'h200);

        // Redirects coinciding with ready: the response stays live.
        applyStimulus(0, 1, 32'h30);
        applyStimulus(0, 1, 32'h400);
        checkValue("same_valid", {31'd0, obsValid}, 32'd1);
        checkValue("same_pc", obsPc, 32'h30);
        applyStimulus(0, 1, 32'hFFFF_FFF8);
        checkValue("same_next", obsAddr, 32'h400);

        // Address wrap.
        applyStimulus(0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0);
        checkValue("wrap_pre", obsAddr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 32'd0);
        checkValue("wrap_addr", obsAddr, 32'h0);

        // Reset during an outstanding request, with a stray response in BOOT.
        icLat = 2;
        applyStimulus(0, 0, 32'd0);
        doReset();
        icPending = 1'b1;
        icCount   = 0;
        icLat     = 0;
        applyStimulus(0, 0, 32'd0);
        checkValue("stray_ready", {31'd0, obsReady}, 32'd1);
        checkValue("stray_valid", {31'd0, obsValid}, 32'd0);
        applyStimulus(0, 0, 32'd0);
        checkValue("restart_addr", obsAddr, IF_RESET_PC);

        // Random stall/redirect traffic with random Icache latency.
        icRandom = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic        rs;
            logic        rj;
            logic [31:0] rt;
            rs = ($urandom_range(0, 9) < 3);
            rj = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       rt = $urandom();
                1:       rt = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
                default: rt = $urandom() & 32'h0000_0FFC;
            endcase
            applyStimulus(rs, rj, rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
